// File: rtl/cheri_lsu_bgarb_pkg.sv
// Shared types and constants for the LSU background-request arbiter.
// The optional aging logic is enabled by CHERI_BGARB_AGING_EN.
package cheri_lsu_bgarb_pkg;

    localparam int BGARB_MAX_MSTR    = 8;
    localparam int BGARB_MODE_STRICT = 0;
    localparam int BGARB_MODE_RR     = 1;
    localparam int BGARB_AGE_W       = 4;

    typedef struct packed {
        logic        is_cap;
        logic        we;
        logic [31:0] addr;
        logic [32:0] wdata;
    } bgarb_req_t;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } bgarb_lock_e;

    function automatic int bgarb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cheri_lsu_bgarb_if.sv
// Bus bundle between the background engines, the arbiter and the LSU port.
// Handshake: a request is held while lsu_req_o is high and is accepted in the
// cycle lsu_req_done_i is high; responses return in issue order, one per
// lsu_resp_valid_i pulse.
interface cheri_lsu_bgarb_if
    import cheri_lsu_bgarb_pkg::*;
#(
    parameter int NMSTR = 2
);
    logic [NMSTR-1:0]    mstr_req_i;
    logic [NMSTR-1:0]    mstr_is_cap_i;
    logic [NMSTR-1:0]    mstr_we_i;
    logic [NMSTR*32-1:0] mstr_addr_i;
    logic [NMSTR*33-1:0] mstr_wdata_i;
    logic [NMSTR-1:0]    mstr_req_done_o;
    logic [NMSTR-1:0]    mstr_resp_valid_o;

    logic                lsu_sel_i;
    logic                lsu_req_done_i;
    logic                lsu_resp_valid_i;
    logic                lsu_req_o;
    logic                lsu_is_cap_o;
    logic                lsu_we_o;
    logic [31:0]         lsu_addr_o;
    logic [32:0]         lsu_wdata_o;

    logic                outst_full_o;
    logic                arb_err_o;
    bgarb_lock_e         dbg_lock_state_o;

    modport slave (
        input  mstr_req_i, mstr_is_cap_i, mstr_we_i, mstr_addr_i, mstr_wdata_i,
        input  lsu_sel_i, lsu_req_done_i, lsu_resp_valid_i,
        output mstr_req_done_o, mstr_resp_valid_o,
        output lsu_req_o, lsu_is_cap_o, lsu_we_o, lsu_addr_o, lsu_wdata_o,
        output outst_full_o, arb_err_o, dbg_lock_state_o
    );

    modport master (
        output mstr_req_i, mstr_is_cap_i, mstr_we_i, mstr_addr_i, mstr_wdata_i,
        output lsu_sel_i, lsu_req_done_i, lsu_resp_valid_i,
        input  mstr_req_done_o, mstr_resp_valid_o,
        input  lsu_req_o, lsu_is_cap_o, lsu_we_o, lsu_addr_o, lsu_wdata_o,
        input  outst_full_o, arb_err_o, dbg_lock_state_o
    );

endinterface

// File: rtl/cheri_bgarb_rsp_fifo.sv
// Response-routing FIFO: remembers which master issued each outstanding
// request. Push and pop in the same cycle is allowed even when full.
module cheri_bgarb_rsp_fifo #(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(Depth));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cheri_lsu_bgarb.sv
// N-master arbiter for the LSU background-request port with lock-until-accept
// and in-order response routing. Define CHERI_BGARB_AGING_EN for starvation aging.
module cheri_lsu_bgarb
    import cheri_lsu_bgarb_pkg::*;
#(
    parameter int NMSTR          = 2,
    parameter int ArbMode        = 0,
    parameter int MaxOutstanding = 2,
    parameter int StarveLimit    = 15
) (
    input logic                clk_i,
    input logic                rst_ni,
    cheri_lsu_bgarb_if.slave   bus
);

    localparam int IW = bgarb_idx_w(NMSTR);

    if (NMSTR < 2 || NMSTR > BGARB_MAX_MSTR || MaxOutstanding < 1 || MaxOutstanding > 4 ||
        StarveLimit < 1 || StarveLimit > 15) begin : g_bad_cfg
        $error("cheri_lsu_bgarb: parameter out of range");
    end

    bgarb_req_t       reqs [NMSTR];
    bgarb_req_t       sel_req;
    bgarb_lock_e      lock_state_q, lock_state_d;
    logic [IW-1:0]    lock_idx_q, lock_idx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             arb_err_q, arb_err_d;
    logic [IW-1:0]    win_idx, eff_idx, head_idx;
    logic             locked, lsu_req, grant;
    logic             fifo_full, fifo_empty;
    logic [NMSTR-1:0] grant_oh;

    function automatic logic [NMSTR-1:0] onehot(input logic [IW-1:0] idx);
        logic [NMSTR-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IW-1:0] pick_low(input logic [NMSTR-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NMSTR - 1; i >= 0; i--) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Scan from the pointer upwards, wrapping once around the ring.
    function automatic logic [IW-1:0] pick_rr(input logic [NMSTR-1:0] v,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] r;
        logic          f;
        int            j;
        r = '0;
        f = 1'b0;
        for (int k = 0; k < NMSTR; k++) begin
            j = int'(ptr) + k;
            if (j >= NMSTR) j = j - NMSTR;
            if (!f && v[IW'(j)]) begin
                f = 1'b1;
                r = IW'(j);
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NMSTR; i++) begin
            reqs[i].is_cap = bus.mstr_is_cap_i[i];
            reqs[i].we     = bus.mstr_we_i[i];
            reqs[i].addr   = bus.mstr_addr_i[32*i +: 32];
            reqs[i].wdata  = bus.mstr_wdata_i[33*i +: 33];
        end
    end

`ifdef CHERI_BGARB_AGING_EN
    logic [BGARB_AGE_W-1:0] age_q [NMSTR];
    logic [BGARB_AGE_W-1:0] age_d [NMSTR];
    logic [NMSTR-1:0]       aged;

    always_comb begin
        for (int i = 0; i < NMSTR; i++) begin
            aged[i]  = bus.mstr_req_i[i] & (age_q[i] >= BGARB_AGE_W'(StarveLimit));
            age_d[i] = age_q[i];
            if (grant_oh[i]) begin
                age_d[i] = '0;
            end else if (bus.mstr_req_i[i] && age_q[i] != '1) begin
                age_d[i] = age_q[i] + BGARB_AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NMSTR; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NMSTR; i++) age_q[i] <= age_d[i];
        end
    end
`endif

    always_comb begin
        win_idx = '0;
        if (ArbMode == BGARB_MODE_RR) win_idx = pick_rr(bus.mstr_req_i, rr_ptr_q);
        else                          win_idx = pick_low(bus.mstr_req_i);
`ifdef CHERI_BGARB_AGING_EN
        if (|aged) win_idx = pick_low(aged);
`endif
    end

    // A lock taken while the FIFO had room keeps the request presented even
    // if the FIFO has since filled or the master has dropped its request.
    assign locked   = (lock_state_q == LOCK_HELD);
    assign eff_idx  = locked ? lock_idx_q : win_idx;
    assign lsu_req  = locked | (|bus.mstr_req_i & ~fifo_full);
    assign grant    = bus.lsu_req_done_i & lsu_req;
    assign grant_oh = grant ? onehot(eff_idx) : '0;
    assign sel_req  = reqs[eff_idx];

    always_comb begin
        lock_state_d = lock_state_q;
        lock_idx_d   = lock_idx_q;
        case (lock_state_q)
            LOCK_IDLE: begin
                if (lsu_req && !bus.lsu_req_done_i && bus.lsu_sel_i) begin
                    lock_state_d = LOCK_HELD;
                    lock_idx_d   = win_idx;
                end
            end
            LOCK_HELD: begin
                if (bus.lsu_req_done_i) lock_state_d = LOCK_IDLE;
            end
            default: lock_state_d = LOCK_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        arb_err_d = arb_err_q | (bus.lsu_resp_valid_i & fifo_empty);
        if (grant) rr_ptr_d = (eff_idx == IW'(NMSTR - 1)) ? '0 : eff_idx + IW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_state_q <= LOCK_IDLE;
            lock_idx_q   <= '0;
            rr_ptr_q     <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_idx_q   <= lock_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            arb_err_q    <= arb_err_d;
        end
    end

    cheri_bgarb_rsp_fifo #(
        .Width (IW),
        .Depth (MaxOutstanding)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .data_i  (eff_idx),
        .pop_i   (bus.lsu_resp_valid_i),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.mstr_req_done_o   = grant_oh;
    assign bus.mstr_resp_valid_o = (bus.lsu_resp_valid_i && !fifo_empty) ? onehot(head_idx) : '0;
    assign bus.lsu_req_o         = lsu_req;
    assign bus.lsu_is_cap_o      = sel_req.is_cap;
    assign bus.lsu_we_o          = sel_req.we;
    assign bus.lsu_addr_o        = sel_req.addr;
    assign bus.lsu_wdata_o       = sel_req.wdata;
    assign bus.outst_full_o      = fifo_full;
    assign bus.arb_err_o         = arb_err_q;
    assign bus.dbg_lock_state_o  = lock_state_q;

endmodule

// File: tb/tb_cheri_lsu_bgarb.sv
// Bench for cheri_lsu_bgarb: a strict-priority and a round-robin instance,
// three masters each, two outstanding responses.
module tb_cheri_lsu_bgarb;
    import cheri_lsu_bgarb_pkg::*;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;
    localparam logic [31:0] A2 = 32'h3000_0080;
    localparam logic [32:0] D0 = 33'h0_1111_0000;
    localparam logic [32:0] D1 = 33'h1_2222_0001;
    localparam logic [32:0] D2 = 33'h0_3333_0002;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [34:0] exp_gs[$];
    logic [34:0] exp_gr[$];
    logic [2:0]  exp_rs[$];
    logic [2:0]  exp_rr[$];

    always #5 clk = ~clk;

    cheri_lsu_bgarb_if #(.NMSTR(3)) if_s ();
    cheri_lsu_bgarb_if #(.NMSTR(3)) if_r ();

    cheri_lsu_bgarb #(.NMSTR(3), .ArbMode(BGARB_MODE_STRICT), .MaxOutstanding(2), .StarveLimit(15))
        dut_s (.clk_i(clk), .rst_ni(rst_n), .bus(if_s.slave));
    cheri_lsu_bgarb #(.NMSTR(3), .ArbMode(BGARB_MODE_RR), .MaxOutstanding(2), .StarveLimit(15))
        dut_r (.clk_i(clk), .rst_ni(rst_n), .bus(if_r.slave));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_s(input logic [2:0] req, input logic done, input logic sel, input logic resp);
        if_s.mstr_req_i       = req;
        if_s.lsu_req_done_i   = done;
        if_s.lsu_sel_i        = sel;
        if_s.lsu_resp_valid_i = resp;
    endtask

    task automatic drv_r(input logic [2:0] req, input logic done, input logic resp);
        if_r.mstr_req_i       = req;
        if_r.lsu_req_done_i   = done;
        if_r.lsu_sel_i        = 1'b0;
        if_r.lsu_resp_valid_i = resp;
    endtask

    // Monitor: every grant or response pulse pops the matching expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_s.mstr_req_done_o != 3'b000) begin
                if (exp_gs.size() == 0) chk("s_grant_unexpected", 64'(if_s.mstr_req_done_o), 64'd0);
                else chk("s_grant", 64'({if_s.mstr_req_done_o, if_s.lsu_addr_o}), 64'(exp_gs.pop_front()));
            end
            if (if_s.mstr_resp_valid_o != 3'b000) begin
                if (exp_rs.size() == 0) chk("s_resp_unexpected", 64'(if_s.mstr_resp_valid_o), 64'd0);
                else chk("s_resp", 64'(if_s.mstr_resp_valid_o), 64'(exp_rs.pop_front()));
            end
            if (if_r.mstr_req_done_o != 3'b000) begin
                if (exp_gr.size() == 0) chk("r_grant_unexpected", 64'(if_r.mstr_req_done_o), 64'd0);
                else chk("r_grant", 64'({if_r.mstr_req_done_o, if_r.lsu_addr_o}), 64'(exp_gr.pop_front()));
            end
            if (if_r.mstr_resp_valid_o != 3'b000) begin
                if (exp_rr.size() == 0) chk("r_resp_unexpected", 64'(if_r.mstr_resp_valid_o), 64'd0);
                else chk("r_resp", 64'(if_r.mstr_resp_valid_o), 64'(exp_rr.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        if_s.mstr_is_cap_i = 3'b010;
        if_s.mstr_we_i     = 3'b100;
        if_s.mstr_addr_i   = {A2, A1, A0};
        if_s.mstr_wdata_i  = {D2, D1, D0};
        if_r.mstr_is_cap_i = 3'b010;
        if_r.mstr_we_i     = 3'b100;
        if_r.mstr_addr_i   = {A2, A1, A0};
        if_r.mstr_wdata_i  = {D2, D1, D0};
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        drv_r(3'b000, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset state
        @(negedge clk);
        chk("rst_lsu_req", 64'(if_s.lsu_req_o), 64'd0);
        chk("rst_full", 64'(if_s.outst_full_o), 64'd0);
        chk("rst_err", 64'(if_s.arb_err_o), 64'd0);
        chk("rst_req_done", 64'(if_s.mstr_req_done_o), 64'd0);
        chk("rst_resp_valid", 64'(if_s.mstr_resp_valid_o), 64'd0);
        chk("rst_r_lsu_req", 64'(if_r.lsu_req_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Strict priority with same-cycle accept, response next cycle
        drv_s(3'b110, 1'b1, 1'b0, 1'b0);
        exp_gs.push_back({3'b010, A1});
        exp_rs.push_back(3'b010);
        @(negedge clk);
        chk("t1_addr", 64'(if_s.lsu_addr_o), 64'(A1));
        chk("t1_wdata", 64'(if_s.lsu_wdata_o), 64'(D1));
        chk("t1_is_cap", 64'(if_s.lsu_is_cap_o), 64'd1);
        chk("t1_we", 64'(if_s.lsu_we_o), 64'd0);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        tick();

        // Lock held while the LSU serves CPU traffic
        drv_s(3'b010, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        drv_s(3'b011, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_lock_addr", 64'(if_s.lsu_addr_o), 64'(A1));
        chk("t2_lock_state", 64'(if_s.dbg_lock_state_o), 64'(LOCK_HELD));
        tick();
        drv_s(3'b011, 1'b1, 1'b1, 1'b0);
        exp_gs.push_back({3'b010, A1});
        exp_rs.push_back(3'b010);
        tick();
        drv_s(3'b001, 1'b1, 1'b0, 1'b0);
        exp_gs.push_back({3'b001, A0});
        exp_rs.push_back(3'b001);
        @(negedge clk);
        chk("t2_after_unlock_addr", 64'(if_s.lsu_addr_o), 64'(A0));
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        tick();

        // Unlocked: a higher-priority request takes over the same cycle
        drv_s(3'b010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_addr_m1", 64'(if_s.lsu_addr_o), 64'(A1));
        tick();
        drv_s(3'b011, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_switch_m0", 64'(if_s.lsu_addr_o), 64'(A0));
        tick();
        drv_s(3'b011, 1'b1, 1'b0, 1'b0);
        exp_gs.push_back({3'b001, A0});
        exp_rs.push_back(3'b001);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        tick();

        // FIFO full blocks new requests; first response goes to first grant
        drv_s(3'b100, 1'b1, 1'b0, 1'b0);
        exp_gs.push_back({3'b100, A2});
        exp_rs.push_back(3'b100);
        tick();
        drv_s(3'b010, 1'b1, 1'b0, 1'b0);
        exp_gs.push_back({3'b010, A1});
        exp_rs.push_back(3'b010);
        tick();
        drv_s(3'b110, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_full", 64'(if_s.outst_full_o), 64'd1);
        chk("t5_req_blocked", 64'(if_s.lsu_req_o), 64'd0);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        drv_s(3'b010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_not_full", 64'(if_s.outst_full_o), 64'd0);
        chk("t5_req_back", 64'(if_s.lsu_req_o), 64'd1);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        tick();

        // Response with nothing outstanding
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_no_resp", 64'(if_s.mstr_resp_valid_o), 64'd0);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_err_set", 64'(if_s.arb_err_o), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_err_sticky", 64'(if_s.arb_err_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_err_reset", 64'(if_s.arb_err_o), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Round-robin, all requesting, accepted every cycle
        drv_r(3'b111, 1'b1, 1'b0);
        exp_gr.push_back({3'b001, A0});
        exp_rr.push_back(3'b001);
        tick();
        drv_r(3'b111, 1'b1, 1'b1);
        exp_gr.push_back({3'b010, A1});
        exp_rr.push_back(3'b010);
        tick();
        exp_gr.push_back({3'b100, A2});
        exp_rr.push_back(3'b100);
        tick();
        exp_gr.push_back({3'b001, A0});
        exp_rr.push_back(3'b001);
        tick();
        drv_r(3'b000, 1'b0, 1'b1);
        tick();
        drv_r(3'b000, 1'b0, 1'b0);
        tick();

`ifdef CHERI_BGARB_AGING_EN
        // Master 1 waits 15 cycles behind master 0, then wins
        for (int c = 1; c <= 16; c++) begin
            drv_s(3'b011, 1'b1, 1'b0, (c > 1));
            if (c <= 15) begin
                exp_gs.push_back({3'b001, A0});
                exp_rs.push_back(3'b001);
            end else begin
                exp_gs.push_back({3'b010, A1});
                exp_rs.push_back(3'b010);
            end
            tick();
        end
        drv_s(3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        drv_s(3'b000, 1'b0, 1'b0, 1'b0);
        tick();
`endif

        @(negedge clk);
        chk("left_s_grants", 64'(exp_gs.size()), 64'd0);
        chk("left_s_resps", 64'(exp_rs.size()), 64'd0);
        chk("left_r_grants", 64'(exp_gr.size()), 64'd0);
        chk("left_r_resps", 64'(exp_rr.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
